// File: rtl/branch_checkpoint_queue_pkg.sv
// Shared types for the branch checkpoint queue: checkpoint layout, recovery FSM states
// and default geometry.
package branch_checkpoint_queue_pkg;

   localparam int CKPT_DEPTH_DEF   = 16;
   localparam int CKPT_PC_W_DEF    = 32;
   localparam int CKPT_GHIST_W_DEF = 8;
   localparam int PTR_W            = $clog2(CKPT_DEPTH_DEF);
   localparam int CNT_OCC_W        = PTR_W + 1;

   typedef enum logic {
      NORMAL  = 1'b0,
      RECOVER = 1'b1
   } rec_state_e;

   // Checkpoint layout at the default widths; the queue rebuilds it at its own widths.
   typedef struct packed {
      logic [CKPT_PC_W_DEF-1:0]    pc;
      logic [CKPT_GHIST_W_DEF-1:0] ghist;
      logic                        pred;
      logic                        pred_gshare;
      logic                        pred_2bit;
      logic [CKPT_PC_W_DEF-1:0]    recovery;
   } branch_ckpt_t;

endpackage

// File: rtl/branch_checkpoint_queue_ckpt_ring_buffer.sv
// Circular checkpoint storage with read/write pointers and exact occupancy count.
// Flush squashes everything younger than the entry being popped.
module ckpt_ring_buffer #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [DATA_W-1:0]          wr_data_i,
   output logic [DATA_W-1:0]          rd_data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (pop_i) rd_ptr_d = rd_ptr_q + 1'b1;
      if (flush_i) begin
         wr_ptr_d = rd_ptr_q + 1'b1;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;
   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);

endmodule

// File: rtl/branch_checkpoint_queue.sv
// In-order branch checkpoint queue: resolves commits against stored predictions and
// drives mispredict/redirect. Optional statistics under BRANCH_CKPT_STATS_EN.
module branch_checkpoint_queue
   import branch_checkpoint_queue_pkg::*;
#(
   parameter int DEPTH       = CKPT_DEPTH_DEF,
   parameter int PC_W        = CKPT_PC_W_DEF,
   parameter int GHIST_W     = CKPT_GHIST_W_DEF,
   parameter int RECOVER_CYC = 2
`ifdef BRANCH_CKPT_STATS_EN
   , parameter int CNT_W     = 32
`endif
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push_valid,
   input  logic [PC_W-1:0]         push_pc,
   input  logic [GHIST_W-1:0]      push_ghist,
   input  logic                    push_pred,
   input  logic                    push_pred_gshare,
   input  logic                    push_pred_2bit,
   input  logic [PC_W-1:0]         push_recovery,
   output logic                    push_ready,
   input  logic                    commit_valid,
   input  logic                    commit_outcome,
   output logic                    head_valid,
   output logic [PC_W-1:0]         head_pc,
   output logic [GHIST_W-1:0]      head_ghist,
   output logic                    head_pred_gshare,
   output logic                    head_pred_2bit,
   output logic                    mispredict,
   output logic [PC_W-1:0]         redirect_pc,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    overflow_err,
   output logic                    underflow_err
`ifdef BRANCH_CKPT_STATS_EN
   , output logic [CNT_W-1:0]      stat_commits
   , output logic [CNT_W-1:0]      stat_mispredicts
   , output logic [CNT_W-1:0]      stat_gshare_correct
   , output logic [CNT_W-1:0]      stat_2bit_correct
`endif
);

   localparam int RCNT_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [GHIST_W-1:0] ghist;
      logic               pred;
      logic               pred_gshare;
      logic               pred_2bit;
      logic [PC_W-1:0]    recovery;
   } ckpt_t;

   ckpt_t             push_entry, head_entry;
   logic              rb_empty, rb_full;
   logic              commit_fire, mis_det, push_fire;
   rec_state_e        state_q, state_d;
   logic [RCNT_W-1:0] rcnt_q, rcnt_d;
   logic              mispredict_q;
   logic [PC_W-1:0]   redirect_q;
   logic              ovf_q, udf_q;

   assign push_entry.pc          = push_pc;
   assign push_entry.ghist       = push_ghist;
   assign push_entry.pred        = push_pred;
   assign push_entry.pred_gshare = push_pred_gshare;
   assign push_entry.pred_2bit   = push_pred_2bit;
   assign push_entry.recovery    = push_recovery;

   assign head_valid  = !rb_empty;
   assign push_ready  = (state_q == NORMAL) && !rb_full;
   assign commit_fire = commit_valid && head_valid;
   assign mis_det     = commit_fire && (commit_outcome != head_entry.pred);
   // A push coinciding with a mispredict is younger than the bad branch, so it dies too.
   assign push_fire   = push_valid && push_ready && !mis_det;

   ckpt_ring_buffer #(
      .DEPTH  (DEPTH),
      .DATA_W ($bits(ckpt_t))
   ) u_ring (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (push_fire),
      .pop_i     (commit_fire),
      .flush_i   (mis_det),
      .wr_data_i (push_entry),
      .rd_data_o (head_entry),
      .count_o   (count),
      .full_o    (rb_full),
      .empty_o   (rb_empty)
   );

   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      case (state_q)
         NORMAL: begin
            if (mis_det) begin
               state_d = RECOVER;
               rcnt_d  = RCNT_W'(RECOVER_CYC - 1);
            end
         end
         RECOVER: begin
            if (rcnt_q == '0) state_d = NORMAL;
            else              rcnt_d  = rcnt_q - 1'b1;
         end
         default: state_d = NORMAL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= NORMAL;
         rcnt_q       <= '0;
         mispredict_q <= 1'b0;
         redirect_q   <= '0;
         ovf_q        <= 1'b0;
         udf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         rcnt_q       <= rcnt_d;
         mispredict_q <= mis_det;
         if (mis_det) redirect_q <= head_entry.recovery;
         if (push_valid && !push_ready && (state_q == NORMAL)) ovf_q <= 1'b1;
         if (commit_valid && !head_valid) udf_q <= 1'b1;
      end
   end

   assign head_pc          = head_entry.pc;
   assign head_ghist       = head_entry.ghist;
   assign head_pred_gshare = head_entry.pred_gshare;
   assign head_pred_2bit   = head_entry.pred_2bit;
   assign mispredict       = mispredict_q;
   assign redirect_pc      = redirect_q;
   assign full             = rb_full;
   assign overflow_err     = ovf_q;
   assign underflow_err    = udf_q;

`ifdef BRANCH_CKPT_STATS_EN
   logic [CNT_W-1:0] st_commits_q, st_mis_q, st_gsh_q, st_bim_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && !(&v)) ? v + 1'b1 : v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_commits_q <= '0;
         st_mis_q     <= '0;
         st_gsh_q     <= '0;
         st_bim_q     <= '0;
      end else begin
         st_commits_q <= sat_inc(st_commits_q, commit_fire);
         st_mis_q     <= sat_inc(st_mis_q, mis_det);
         st_gsh_q     <= sat_inc(st_gsh_q, commit_fire && (head_entry.pred_gshare == commit_outcome));
         st_bim_q     <= sat_inc(st_bim_q, commit_fire && (head_entry.pred_2bit == commit_outcome));
      end
   end

   assign stat_commits        = st_commits_q;
   assign stat_mispredicts    = st_mis_q;
   assign stat_gshare_correct = st_gsh_q;
   assign stat_2bit_correct   = st_bim_q;

`ifdef SIMULATION
   string last_stats_event;
   event  stats_evt;

   task automatic stats_event(input string name);
      last_stats_event = name;
      ->stats_evt;
   endtask

   always @(posedge clk) begin
      if (mispredict_q) stats_event("branch_mispredict");
   end
`endif
`endif

endmodule

// File: tb/tb_branch_checkpoint_queue.sv
// Randomised scoreboard bench for branch_checkpoint_queue against a queue-based model.
module tb_branch_checkpoint_queue;

   localparam int DEPTH       = 4;
   localparam int PC_W        = 32;
   localparam int GHIST_W     = 8;
   localparam int RECOVER_CYC = 2;
   localparam int OCC_W       = $clog2(DEPTH) + 1;

   typedef struct {
      logic [31:0] pc;
      logic [7:0]  ghist;
      logic        pred;
      logic        g;
      logic        b;
      logic [31:0] rec;
   } ent_t;

   typedef struct {
      logic        mis;
      logic [31:0] redir;
      int          cnt;
      logic        full;
      logic        hv;
      logic        ready;
      logic        ovf;
      logic        udf;
      ent_t        head;
   } exp_t;

   logic               clk, rst_n;
   logic               push_valid, push_pred, push_pred_gshare, push_pred_2bit;
   logic [PC_W-1:0]    push_pc, push_recovery;
   logic [GHIST_W-1:0] push_ghist;
   logic               push_ready, commit_valid, commit_outcome;
   logic               head_valid, head_pred_gshare, head_pred_2bit;
   logic [PC_W-1:0]    head_pc, redirect_pc;
   logic [GHIST_W-1:0] head_ghist;
   logic               mispredict, full, overflow_err, underflow_err;
   logic [OCC_W-1:0]   count;
`ifdef BRANCH_CKPT_STATS_EN
   logic [31:0]        stat_commits, stat_mispredicts, stat_gshare_correct, stat_2bit_correct;
`endif

   branch_checkpoint_queue #(
      .DEPTH       (DEPTH),
      .PC_W        (PC_W),
      .GHIST_W     (GHIST_W),
      .RECOVER_CYC (RECOVER_CYC)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .push_valid       (push_valid),
      .push_pc          (push_pc),
      .push_ghist       (push_ghist),
      .push_pred        (push_pred),
      .push_pred_gshare (push_pred_gshare),
      .push_pred_2bit   (push_pred_2bit),
      .push_recovery    (push_recovery),
      .push_ready       (push_ready),
      .commit_valid     (commit_valid),
      .commit_outcome   (commit_outcome),
      .head_valid       (head_valid),
      .head_pc          (head_pc),
      .head_ghist       (head_ghist),
      .head_pred_gshare (head_pred_gshare),
      .head_pred_2bit   (head_pred_2bit),
      .mispredict       (mispredict),
      .redirect_pc      (redirect_pc),
      .count            (count),
      .full             (full),
      .overflow_err     (overflow_err),
      .underflow_err    (underflow_err)
`ifdef BRANCH_CKPT_STATS_EN
      , .stat_commits        (stat_commits)
      , .stat_mispredicts    (stat_mispredicts)
      , .stat_gshare_correct (stat_gshare_correct)
      , .stat_2bit_correct   (stat_2bit_correct)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   ent_t        mq[$];
   exp_t        exp_q[$];
   int          rec_left = 0;
   logic        m_ovf = 1'b0, m_udf = 1'b0;
   logic [31:0] m_redir = '0;
   int          cyc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, req);
      end
   endtask

   function automatic ent_t mk(input logic [31:0] pc, input logic pred, input logic [31:0] rec);
      ent_t c;
      c.pc = pc; c.pred = pred; c.rec = rec;
      c.ghist = 8'($urandom); c.g = 1'($urandom); c.b = 1'($urandom);
      return c;
   endfunction

   task automatic model_reset();
      mq.delete();
      rec_left = 0; m_ovf = 1'b0; m_udf = 1'b0; m_redir = '0;
   endtask

   // Reference behaviour: a FIFO of checkpoints plus a count of remaining blocked cycles.
   task automatic model_step(input logic pv, input ent_t c, input logic cv, input logic oc);
      exp_t e;
      ent_t h, z;
      logic ready, mis;
      z = '{pc: '0, ghist: '0, pred: 1'b0, g: 1'b0, b: 1'b0, rec: '0};
      ready = (rec_left == 0) && (mq.size() < DEPTH);
      mis = 1'b0;
      if (cv) begin
         if (mq.size() == 0) m_udf = 1'b1;
         else begin
            h = mq.pop_front();
            if (h.pred !== oc) begin
               mis = 1'b1;
               m_redir = h.rec;
            end
         end
      end
      if (pv) begin
         if (ready && !mis) mq.push_back(c);
         else if (!ready && rec_left == 0) m_ovf = 1'b1;
      end
      if (mis) begin
         mq.delete();
         rec_left = RECOVER_CYC;
      end else if (rec_left > 0) rec_left--;
      e.mis = mis; e.redir = m_redir; e.cnt = mq.size();
      e.full = (mq.size() == DEPTH); e.hv = (mq.size() > 0);
      e.ready = (rec_left == 0) && (mq.size() < DEPTH);
      e.ovf = m_ovf; e.udf = m_udf;
      e.head = e.hv ? mq[0] : z;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic pv, input ent_t c, input logic cv, input logic oc);
      push_valid = pv; push_pc = c.pc; push_ghist = c.ghist; push_pred = c.pred;
      push_pred_gshare = c.g; push_pred_2bit = c.b; push_recovery = c.rec;
      commit_valid = cv; commit_outcome = oc;
   endtask

   task automatic step(input logic pv, input ent_t c, input logic cv, input logic oc);
      @(negedge clk);
      drive(pv, c, cv, oc);
      model_step(pv, c, cv, oc);
   endtask

   function automatic logic front_pred();
      return (mq.size() > 0) ? mq[0].pred : 1'b0;
   endfunction

   // Monitor: compares each post-edge DUT state against the oldest expectation.
   exp_t mon_e;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            $display("cyc %0d: cnt=%0d mis=%0b ready=%0b head_pc=%0h", cyc, count, mispredict,
                     push_ready, head_pc);
            chk("mispredict", 64'(mispredict), 64'(mon_e.mis));
            chk("redirect_pc", 64'(redirect_pc), 64'(mon_e.redir));
            chk("count", 64'(count), 64'(mon_e.cnt));
            chk("full", 64'(full), 64'(mon_e.full));
            chk("head_valid", 64'(head_valid), 64'(mon_e.hv));
            chk("push_ready", 64'(push_ready), 64'(mon_e.ready));
            chk("overflow_err", 64'(overflow_err), 64'(mon_e.ovf));
            chk("underflow_err", 64'(underflow_err), 64'(mon_e.udf));
            if (mon_e.hv) begin
               chk("head_pc", 64'(head_pc), 64'(mon_e.head.pc));
               chk("head_ghist", 64'(head_ghist), 64'(mon_e.head.ghist));
               chk("head_pred_gshare", 64'(head_pred_gshare), 64'(mon_e.head.g));
               chk("head_pred_2bit", 64'(head_pred_2bit), 64'(mon_e.head.b));
            end
         end
      end
   end

   task automatic check_reset_values(input string tag);
      chk({tag, "_count"}, 64'(count), 64'd0);
      chk({tag, "_mispredict"}, 64'(mispredict), 64'd0);
      chk({tag, "_redirect_pc"}, 64'(redirect_pc), 64'd0);
      chk({tag, "_overflow_err"}, 64'(overflow_err), 64'd0);
      chk({tag, "_underflow_err"}, 64'(underflow_err), 64'd0);
      chk({tag, "_head_valid"}, 64'(head_valid), 64'd0);
      chk({tag, "_full"}, 64'(full), 64'd0);
      chk({tag, "_push_ready"}, 64'(push_ready), 64'd1);
   endtask

   ent_t idle;
   logic pv_r, cv_r, oc_r;

   initial begin
      idle = '{pc: '0, ghist: '0, pred: 1'b0, g: 1'b0, b: 1'b0, rec: '0};
      rst_n = 1'b0;
      drive(1'b0, idle, 1'b0, 1'b0);
      #3;
      check_reset_values("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // In-order, correctly predicted branches
      step(1'b1, mk(32'h1000, 1'b1, 32'h9000), 1'b0, 1'b0);
      step(1'b1, mk(32'h1004, 1'b0, 32'h9004), 1'b0, 1'b0);
      step(1'b1, mk(32'h1008, 1'b1, 32'h9008), 1'b0, 1'b0);
      step(1'b0, idle, 1'b1, 1'b1);
      step(1'b0, idle, 1'b1, 1'b0);
      step(1'b0, idle, 1'b1, 1'b1);

      // Fill past capacity, then push+commit while full
      for (int i = 0; i < 5; i++) step(1'b1, mk(32'h2000 + 32'(4 * i), 1'($urandom), 32'h0), 1'b0, 1'b0);
      step(1'b1, mk(32'h2100, 1'b0, 32'h0), 1'b1, front_pred());
      while (mq.size() > 0) step(1'b0, idle, 1'b1, front_pred());

      // Mispredict on oldest of three, pushes attempted during recovery
      step(1'b1, mk(32'hA000, 1'b1, 32'h100), 1'b0, 1'b0);
      step(1'b1, mk(32'hB000, 1'b0, 32'h200), 1'b0, 1'b0);
      step(1'b1, mk(32'hC000, 1'b1, 32'h300), 1'b0, 1'b0);
      step(1'b0, idle, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, mk(32'h3000 + 32'(4 * i), 1'b0, 32'h0), 1'b0, 1'b0);
      while (mq.size() > 0) step(1'b0, idle, 1'b1, front_pred());

      // Pointer wrap with back-to-back push/commit pairs
      step(1'b1, mk(32'h4000, 1'($urandom), 32'h0), 1'b0, 1'b0);
      for (int i = 1; i < 3 * DEPTH; i++)
         step(1'b1, mk(32'h4000 + 32'(4 * i), 1'($urandom), 32'h0), 1'b1, front_pred());
      step(1'b0, idle, 1'b1, front_pred());

      // Commit on an empty queue
      step(1'b0, idle, 1'b1, 1'b0);

      // Reset while the mispredict pulse is high
      step(1'b1, mk(32'h5000, 1'b0, 32'h500), 1'b0, 1'b0);
      step(1'b0, idle, 1'b1, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, idle, 1'b0, 1'b0);
      #1;
      check_reset_values("async_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_reset_push_ready", 64'(push_ready), 64'd1);

      // Random traffic with occasional mispredicts
      for (int i = 0; i < 400; i++) begin
         pv_r = 1'($urandom);
         cv_r = 1'($urandom);
         oc_r = (mq.size() > 0) ? (($urandom % 6 == 0) ? ~front_pred() : front_pred()) : 1'($urandom);
         step(pv_r, mk($urandom, 1'($urandom), $urandom), cv_r, oc_r);
      end
      step(1'b0, idle, 1'b0, 1'b0);
      step(1'b0, idle, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
